// File: rtl/apb_manager_bridge.sv
// APB manager bridge: accepts one request at a time on a valid/ready channel,
// decodes it to a one-hot peripheral select, runs the APB SETUP/ACCESS sequence,
// and returns read data and error status on a valid/ready response channel.
module apb_manager_bridge #(
    parameter int unsigned          AddrWidth     = 32,
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          PrphNum       = 1,
    parameter logic [AddrWidth-1:0] BaseAddr      = '0,
    parameter int unsigned          PrphAddrBits  = 12,
    parameter int unsigned          TimeoutCycles = 0
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   reqValid,
    output logic                   reqReady,
    input  logic [AddrWidth-1:0]   reqAddr,
    input  logic                   reqWrite,
    input  logic [DataWidth-1:0]   reqWData,
    input  logic [DataWidth/8-1:0] reqStrb,
    input  logic [3:0]             reqProt,

    output logic                   rspValid,
    input  logic                   rspReady,
    output logic [DataWidth-1:0]   rspRData,
    output logic                   rspError,

    output logic [AddrWidth-1:0]   apbAddr,
    output logic [3:0]             apbProt,
    output logic [PrphNum-1:0]     apbSelectors,
    output logic                   apbEnable,
    output logic                   apbWrite,
    output logic [DataWidth-1:0]   apbWData,
    output logic [DataWidth/8-1:0] apbStrb,
    input  logic                   apbReady,
    input  logic [DataWidth-1:0]   apbRData,
    input  logic                   apbSubError
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned CntWidth  = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
    // Abort fires on the ACCESS cycle whose wait count would reach TimeoutCycles.
    localparam logic [CntWidth-1:0] CntLast =
        (TimeoutCycles == 0) ? '0 : CntWidth'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t state, state_d;

    logic [CntWidth-1:0]  cnt, cnt_d;
    logic [AddrWidth-1:0] addr_d;
    logic [3:0]           prot_d;
    logic [PrphNum-1:0]   sel_d;
    logic                 en_d;
    logic                 write_d;
    logic [DataWidth-1:0] wdata_d;
    logic [StrbWidth-1:0] strb_d;
    logic                 rsp_valid_d;
    logic [DataWidth-1:0] rsp_rdata_d;
    logic                 rsp_error_d;

    logic [AddrWidth-1:0] offset;
    logic [AddrWidth-1:0] index;
    logic                 decode_err;
    logic [PrphNum-1:0]   sel_dec;

    assign reqReady = (state == IDLE) && !reset;

    // Address decode: window index relative to BaseAddr, unsigned with wrap.
    assign offset     = reqAddr - BaseAddr;
    assign index      = offset >> PrphAddrBits;
    assign decode_err = (reqAddr < BaseAddr) || (index >= AddrWidth'(PrphNum));

    // One-hot selector for the decoded peripheral index.
    always_comb begin
        sel_dec = '0;
        for (int unsigned i = 0; i < PrphNum; i++) begin
            sel_dec[i] = (index == AddrWidth'(i));
        end
    end

    // Next-state and next-output logic; every register holds unless updated.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        addr_d      = apbAddr;
        prot_d      = apbProt;
        sel_d       = apbSelectors;
        en_d        = apbEnable;
        write_d     = apbWrite;
        wdata_d     = apbWData;
        strb_d      = apbStrb;
        rsp_valid_d = rspValid;
        rsp_rdata_d = rspRData;
        rsp_error_d = rspError;

        case (state)
            IDLE: begin
                if (reqValid) begin
                    if (decode_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = RESP;
                    end else begin
                        addr_d  = reqAddr;
                        prot_d  = reqProt;
                        write_d = reqWrite;
                        wdata_d = reqWData;
                        strb_d  = reqWrite ? reqStrb : '0;
                        sel_d   = sel_dec;
                        en_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                en_d    = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (apbReady) begin
                    rsp_rdata_d = apbWrite ? '0 : apbRData;
                    rsp_error_d = apbSubError;
                    rsp_valid_d = 1'b1;
                    sel_d       = '0;
                    en_d        = 1'b0;
                    state_d     = RESP;
                end else if ((TimeoutCycles != 0) && (cnt == CntLast)) begin
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    sel_d       = '0;
                    en_d        = 1'b0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RESP: begin
                if (rspReady) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; asynchronous reset drops any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            apbAddr      <= '0;
            apbProt      <= '0;
            apbSelectors <= '0;
            apbEnable    <= 1'b0;
            apbWrite     <= 1'b0;
            apbWData     <= '0;
            apbStrb      <= '0;
            rspValid     <= 1'b0;
            rspRData     <= '0;
            rspError     <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            apbAddr      <= addr_d;
            apbProt      <= prot_d;
            apbSelectors <= sel_d;
            apbEnable    <= en_d;
            apbWrite     <= write_d;
            apbWData     <= wdata_d;
            apbStrb      <= strb_d;
            rspValid     <= rsp_valid_d;
            rspRData     <= rsp_rdata_d;
            rspError     <= rsp_error_d;
        end
    end

endmodule

// File: tb/tb_apb_manager_bridge.sv
// Self-checking bench for apb_manager_bridge: table of transfers with an APB
// peripheral model, response scoreboard, backpressure and mid-transfer reset.
module tb_apb_manager_bridge;

    logic        clk;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic        reqWrite;
    logic [31:0] reqWData;
    logic [3:0]  reqStrb;
    logic [3:0]  reqProt;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspRData;
    logic        rspError;
    logic [31:0] apbAddr;
    logic [3:0]  apbProt;
    logic [3:0]  apbSelectors;
    logic        apbEnable;
    logic        apbWrite;
    logic [31:0] apbWData;
    logic [3:0]  apbStrb;
    logic        apbReady;
    logic [31:0] apbRData;
    logic        apbSubError;

    apb_manager_bridge #(
        .AddrWidth    (32),
        .DataWidth    (32),
        .PrphNum      (4),
        .BaseAddr     (32'h0),
        .PrphAddrBits (12),
        .TimeoutCycles(5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .reqValid    (reqValid),
        .reqReady    (reqReady),
        .reqAddr     (reqAddr),
        .reqWrite    (reqWrite),
        .reqWData    (reqWData),
        .reqStrb     (reqStrb),
        .reqProt     (reqProt),
        .rspValid    (rspValid),
        .rspReady    (rspReady),
        .rspRData    (rspRData),
        .rspError    (rspError),
        .apbAddr     (apbAddr),
        .apbProt     (apbProt),
        .apbSelectors(apbSelectors),
        .apbEnable   (apbEnable),
        .apbWrite    (apbWrite),
        .apbWData    (apbWData),
        .apbStrb     (apbStrb),
        .apbReady    (apbReady),
        .apbRData    (apbRData),
        .apbSubError (apbSubError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [3:0]  prot;
        int          waits;   // ACCESS cycles with apbReady low before completion
        logic        suberr;
        logic [31:0] prdata;
        int          bp;      // cycles rspReady is held low
        logic        dec;     // decode error expected
        logic [3:0]  e_sel;
        int          e_selcyc;
        int          e_encyc;
        int          e_lat;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    vec_t        vt[7];
    int          total = 0;
    int          bad = 0;
    logic [31:0] last_addr = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int          cyc;
        int          acc;
        int          selcyc;
        int          encyc;
        logic [3:0]  selv;
        logic        badf;
        logic        bpok;
        logic [31:0] held;
        exp_t        e;

        cyc = 1; acc = 0; selcyc = 0; encyc = 0; selv = 4'h0; badf = 1'b0; bpok = 1'b1;
        apbReady = 1'b0; apbSubError = 1'b0; apbRData = 32'h0;
        rspReady = 1'b0;
        reqValid = 1'b1;
        reqAddr  = v.addr;
        reqWrite = v.wr;
        reqWData = v.wdata;
        reqStrb  = v.strb;
        reqProt  = v.prot;
        chk($sformatf("v%0d reqReady_before", n), {31'b0, reqReady}, 32'h1);
        sbq.push_back('{rdata: v.e_rdata, err: v.e_err, lat: v.e_lat});
        @(negedge clk);
        reqValid = 1'b0;

        while (cyc < 40) begin
            if (rspValid) break;
            if (apbSelectors != 4'h0) begin
                selcyc++;
                selv = apbSelectors;
                if (apbWData !== v.wdata || apbStrb !== (v.wr ? v.strb : 4'h0) ||
                    apbWrite !== v.wr || apbProt !== v.prot || apbAddr !== v.addr)
                    badf = 1'b1;
            end
            if (apbEnable) begin
                encyc++;
                acc++;
                apbReady    = (acc > v.waits);
                apbRData    = apbReady ? v.prdata : 32'h5A5A5A5A;
                apbSubError = apbReady ? v.suberr : 1'b1;
            end else begin
                apbReady    = 1'b0;
                apbRData    = 32'h0;
                apbSubError = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        apbReady = 1'b0; apbSubError = 1'b0;

        if (!rspValid) begin
            chk($sformatf("v%0d rsp_timeout", n), 32'h0, 32'h1);
            return;
        end
        if (sbq.size() == 0) begin
            chk($sformatf("v%0d sb_empty", n), 32'h0, 32'h1);
            return;
        end
        e = sbq.pop_front();
        chk($sformatf("v%0d latency", n), cyc, e.lat);
        chk($sformatf("v%0d rdata", n), rspRData, e.rdata);
        chk($sformatf("v%0d err", n), {31'b0, rspError}, {31'b0, e.err});
        chk($sformatf("v%0d sel", n), {28'b0, selv}, {28'b0, v.e_sel});
        chk($sformatf("v%0d selcyc", n), selcyc, v.e_selcyc);
        chk($sformatf("v%0d encyc", n), encyc, v.e_encyc);
        chk($sformatf("v%0d apb_fields", n), {31'b0, badf}, 32'h0);
        if (!v.dec) last_addr = v.addr;
        chk($sformatf("v%0d addr_hold", n), apbAddr, last_addr);

        held = rspRData;
        for (int b = 0; b < v.bp; b++) begin
            reqValid = 1'b1;
            reqAddr  = 32'h0000_0000;
            reqWrite = 1'b0;
            @(negedge clk);
            if (!rspValid || rspRData !== held || reqReady || apbSelectors != 4'h0)
                bpok = 1'b0;
        end
        if (v.bp > 0)
            chk($sformatf("v%0d backpressure_hold", n), {31'b0, bpok}, 32'h1);

        reqValid = 1'b0;
        rspReady = 1'b1;
        @(negedge clk);
        rspReady = 1'b0;
        chk($sformatf("v%0d post_hs", n), {30'b0, rspValid, reqReady}, 32'h1);
    endtask

    initial begin
        logic        okq;
        int          guard;

        vt[0] = '{32'h2004, 1'b0, 32'hCAFEF00D, 4'hF, 4'h0, 0, 1'b0, 32'hDEADBEEF, 0, 1'b0,
                  4'b0100, 2, 1, 3, 1'b0, 32'hDEADBEEF};
        vt[1] = '{32'h1000, 1'b1, 32'h12345678, 4'b0011, 4'h2, 3, 1'b0, 32'hAAAA5555, 0, 1'b0,
                  4'b0010, 5, 4, 6, 1'b0, 32'h0};
        vt[2] = '{32'h4000, 1'b0, 32'h0, 4'h0, 4'h0, 0, 1'b0, 32'h0, 0, 1'b1,
                  4'b0000, 0, 0, 1, 1'b1, 32'h0};
        vt[3] = '{32'h3FFC, 1'b0, 32'h0BB0, 4'h0, 4'h1, 1, 1'b1, 32'h0, 0, 1'b0,
                  4'b1000, 3, 2, 4, 1'b1, 32'h0};
        vt[4] = '{32'h0010, 1'b0, 32'h0, 4'h0, 4'h0, 99, 1'b0, 32'hFFFFFFFF, 0, 1'b0,
                  4'b0001, 6, 5, 7, 1'b1, 32'h0};
        vt[5] = '{32'h0ABC, 1'b0, 32'h77, 4'h0, 4'h3, 2, 1'b0, 32'h0BADF00D, 4, 1'b0,
                  4'b0001, 4, 3, 5, 1'b0, 32'h0BADF00D};
        vt[6] = '{32'h3000, 1'b1, 32'hF00DFACE, 4'hF, 4'h0, 0, 1'b1, 32'h99999999, 0, 1'b0,
                  4'b1000, 2, 1, 3, 1'b1, 32'h0};

        reset = 1'b1; reqValid = 1'b0; reqAddr = '0; reqWrite = 1'b0; reqWData = '0;
        reqStrb = '0; reqProt = '0; rspReady = 1'b0; apbReady = 1'b0; apbRData = '0;
        apbSubError = 1'b0;
        #1;
        chk("reset_outputs", {apbSelectors, apbEnable, rspValid, rspError, apbWrite, apbStrb, apbProt},
            32'h0);
        chk("reset_addr_data", apbAddr | apbWData | rspRData, 32'h0);
        chk("reset_reqReady", {31'b0, reqReady}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("release_reqReady", {31'b0, reqReady}, 32'h1);
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vt[i], i);

        // Reset asserted asynchronously while a transfer is in ACCESS.
        reqValid = 1'b1; reqAddr = 32'h1000; reqWrite = 1'b1; reqWData = 32'h13572468;
        reqStrb = 4'hF; reqProt = 4'h5;
        @(negedge clk);
        reqValid = 1'b0;
        guard = 0;
        while (!apbEnable && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_reached_access", {31'b0, apbEnable}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_ctrl", {apbSelectors, apbEnable, rspValid, rspError, apbWrite, apbStrb, apbProt},
            32'h0);
        chk("rst_async_data", apbAddr | apbWData | rspRData, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_release_reqReady", {31'b0, reqReady}, 32'h1);
        okq = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rspValid || apbSelectors != 4'h0 || apbEnable) okq = 1'b0;
        end
        chk("rst_no_response", {31'b0, okq}, 32'h1);
        chk("sb_drained", sbq.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/apb_manager_bridge.md
# apb_manager_bridge

Single-manager APB requester stage that drives the common APB signal bundle from the bridge side. It accepts one request at a time on a valid/ready request channel, decodes the address to a one-hot peripheral selector, and runs the APB SETUP/ACCESS sequence. It then returns read data and error status on a valid/ready response channel. It sits between an upstream bus adapter or CPU load/store port and the APB peripheral mux.

## Interface
- AddrWidth, 32, byte-address width
- DataWidth, 32, data width; multiple of 8
- PrphNum, 1, number of peripherals / selector lanes
- BaseAddr, 0, byte address of peripheral 0
- PrphAddrBits, 12, log2 of bytes per peripheral window
- TimeoutCycles, 0, max ACCESS cycles before abort; 0 disables

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- reqValid  in  1  request present
- reqReady  out  1  request accepted when reqValid && reqReady
- reqAddr  in  AddrWidth  byte address
- reqWrite  in  1  high = write
- reqWData  in  DataWidth  write data
- reqStrb  in  DataWidth/8  write byte strobes
- reqProt  in  4  protection attributes
- rspValid  out  1  response present
- rspReady  in  1  response consumed when rspValid && rspReady
- rspRData  out  DataWidth  read data; 0 for writes and errors
- rspError  out  1  decode error, subordinate error or timeout
- apbAddr  out  AddrWidth  transfer address
- apbProt  out  4  protection
- apbSelectors  out  PrphNum  one-hot peripheral select
- apbEnable  out  1  ACCESS phase
- apbWrite  out  1  direction
- apbWData  out  DataWidth  write data
- apbStrb  out  DataWidth/8  strobes; forced 0 on reads
- apbReady  in  1  subordinate completion
- apbRData  in  DataWidth  read data (already muxed)
- apbSubError  in  1  subordinate error, sampled with apbReady

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB and response outputs are registered.
- reqReady = (state == IDLE) && !reset.
- **IDLE:** on a request handshake, capture all req fields. Decode index = (reqAddr − BaseAddr) >> PrphAddrBits, unsigned with wrap.
  - If reqAddr < BaseAddr or index ≥ PrphNum (decode error): go to RESP with rspError=1, rspRData=0. No APB activity occurs.
  - Otherwise: load apbAddr/apbProt/apbWrite/apbWData/apbStrb (strb=0 if read), set apbSelectors bit[index], apbEnable=0, and go to SETUP.
- **SETUP:** lasts exactly one cycle, then apbEnable=1 and go to ACCESS.
- **ACCESS:** the wait counter increments each cycle apbReady=0.
  - On apbReady=1: rspRData = apbWrite ? 0 : apbRData; rspError = apbSubError. Clear selectors and enable. Go to RESP.
  - If TimeoutCycles≠0 and the counter reaches TimeoutCycles with apbReady still 0: abort. Clear selectors and enable, set rspError=1, rspRData=0, go to RESP.
  - The counter clears on entering SETUP. Its width is clog2(TimeoutCycles+1), minimum 1.
- **RESP:** rspValid=1. Hold rspRData/rspError until rspReady=1, then clear rspValid and go to IDLE.
- apbAddr, apbProt, apbWrite, apbWData and apbStrb hold their last values after a transfer, changing only on the next decoded accept.
- apbReady and apbSubError are ignored outside ACCESS.
- Reset, asynchronous at any time including mid-transfer:
  - state=IDLE.
  - Outputs 0: apbSelectors, apbEnable, rspValid, rspRData, rspError, apbAddr, apbProt, apbWrite, apbWData, apbStrb.
  - The wait counter clears.
  - The in-flight transfer is dropped with no response.

## Timing
- Accept at edge T (IDLE). Selector asserts after T (SETUP cycle). apbEnable asserts after T+1.
- apbReady sampled high at edge T+2 gives zero wait states; rspValid rises after T+2. Minimum accept-to-rspValid is 3 cycles.
- Each wait state adds one cycle.
- A decode error gives rspValid the cycle after accept (latency 1).
- Throughput: one transfer outstanding. The next accept is possible the cycle after the rspValid && rspReady handshake.
- No combinational path from any input to any APB output or to rspValid.

## Test plan
- **Zero-wait read:** PrphNum=4, PrphAddrBits=12, BaseAddr=0. Read 0x2004; peripheral replies apbReady=1 with apbRData=0xDEADBEEF.
  - Expect apbSelectors=4'b0100 for 2 cycles and apbEnable high for 1 cycle.
  - Expect rspValid 3 cycles after accept with rspRData=0xDEADBEEF, rspError=0.
- **Write with waits:** write 0x1000, data 0x12345678, strb 4'b0011; apbReady low for 3 ACCESS cycles.
  - Expect apbStrb=0011 and apbWData stable throughout ACCESS.
  - Expect rspValid 6 cycles after accept with rspRData=0.
- **Decode error:** read 0x4000 with PrphNum=4.
  - Expect no selector and no enable.
  - Expect rspValid 1 cycle after accept with rspError=1.
- **Subordinate error and timeout:** apbSubError=1 with apbReady gives rspError=1. With TimeoutCycles=5 and apbReady held 0, expect abort after 5 ACCESS cycles with rspError=1 and selectors cleared.
- **Response backpressure:** hold rspReady=0 for 4 cycles.
  - Expect rspValid and data held, reqReady=0, no new APB selection.
  - Back-to-back requests resume the cycle after the handshake.
- **Mid-transfer reset:** assert reset during ACCESS.
  - Expect all outputs 0 immediately (asynchronous), no rspValid after release, and reqReady=1 the first cycle after release.
